dual_issue_ctrl: RTL and testbench

- Scheduler and pipeline controller for the dual-issue ID->EX boundary.
- Each cycle it decides whether the decoded pair issues as master+slave, master only, or nothing.
- Drives the per-lane enable/clear pins of the ID/EX register (ena1/ena2/clear1/clear2) and the IF/ID and EX/MEM controls.
- Tells the instruction queue how many entries were consumed.
- Sequences multi-cycle divide stalls and exception/ERET flushes with a small state machine.

---
 rtl/dual_issue_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_dual_issue_ctrl.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dual_issue_ctrl
// Purpose  : Scheduler and pipeline controller for the dual-issue ID->EX
//            boundary. Each cycle it decides whether the decoded pair issues
//            as master+slave, master only, or nothing. It drives the ID/EX
//            per-lane enable/clear pins and the IF/ID and EX/MEM controls,
//            reports how many queue entries were consumed, and sequences
//            divide stalls and exception/ERET flushes.
//
// Parameters:
//   FLUSH_CYCLES  cycles the clears stay high after an exception flush (1..7)
//   DIV_TIMEOUT   watchdog limit for the divide wait, in cycles
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   d_master_valid/d_slave_valid, slave_raw_dep, master_is_mem,
//   slave_is_mem, slave_is_ctrl    pair pairing information from decode
//   load_use, div_start, div_done, mem_stall, except_flush, branch_flush
//                         pipeline hazard / event inputs
//   if_id_ena/clear, id_ex_ena1/2, id_ex_clear1/2, ex_mem_ena/clear
//                         pipeline register controls (combinational)
//   issue_cnt             queue entries consumed this cycle (0..2)
//   div_timeout           sticky divide watchdog flag, cleared by rst only
//
// Optional build macro:
//   ISSUE_STATS_EN        adds saturating counters stat_dual, stat_single,
//                         stat_stall
//
// Revision : 1.0 - initial release
// ============================================================================
module dual_issue_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int DIV_TIMEOUT  = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        d_master_valid,
    input  logic        d_slave_valid,
    input  logic        slave_raw_dep,
    input  logic        master_is_mem,
    input  logic        slave_is_mem,
    input  logic        slave_is_ctrl,
    input  logic        load_use,
    input  logic        div_start,
    input  logic        div_done,
    input  logic        mem_stall,
    input  logic        except_flush,
    input  logic        branch_flush,
    output logic        if_id_ena,
    output logic        if_id_clear,
    output logic        id_ex_ena1,
    output logic        id_ex_ena2,
    output logic        id_ex_clear1,
    output logic        id_ex_clear2,
    output logic        ex_mem_ena,
    output logic        ex_mem_clear,
    output logic [1:0]  issue_cnt,
    output logic        div_timeout
`ifdef ISSUE_STATS_EN
    ,
    output logic [31:0] stat_dual,
    output logic [31:0] stat_single,
    output logic [31:0] stat_stall
`endif
);

    localparam int c_DW = $clog2(DIV_TIMEOUT + 1);

    localparam logic [1:0] c_ST_RUN   = 2'd0;
    localparam logic [1:0] c_ST_DIV   = 2'd1;
    localparam logic [1:0] c_ST_FLUSH = 2'd2;

    logic [1:0]      r_state;
    logic [2:0]      r_flush_cnt;
    logic [c_DW-1:0] r_div_cnt;
    logic            r_div_timeout;

    logic            w_dual;
    logic            w_kill_all;
    logic            w_do_issue;
    logic            w_run_evt;
    logic [c_DW-1:0] w_div_nxt;
    logic            w_div_expire;

    // The slave may only ride along when it is independent of the master,
    // does not share the single memory port, and is not a master-only class.
    assign w_dual = d_master_valid & d_slave_valid & ~slave_raw_dep &
                    ~(master_is_mem & slave_is_mem) & ~slave_is_ctrl;

    // Reset, a committed exception and the flush window all clear every stage.
    assign w_kill_all = rst | except_flush | (r_state == c_ST_FLUSH);

    // RUN with no stall-class event pending: load_use / branch_flush decide.
    assign w_run_evt = (r_state == c_ST_RUN) & ~mem_stall & ~div_start;

    // Normal issue: plain RUN with no events, or the cycle the divider
    // returns its result (the divide leaves E and the pair may follow it).
    assign w_do_issue = ~w_kill_all &
                        (((r_state == c_ST_DIV) & div_done) |
                         (w_run_evt & ~load_use & ~branch_flush));

    assign w_div_nxt    = r_div_cnt + c_DW'(1);
    assign w_div_expire = (w_div_nxt == c_DW'(DIV_TIMEOUT));

    assign div_timeout = r_div_timeout;

    // ------------------------------------------------------------------
    // Pipeline controls. Lane enables are the complement of lane clears
    // when issuing so a lane is never loaded and flushed at once.
    // ------------------------------------------------------------------
    always_comb begin
        if_id_ena    = 1'b0;
        if_id_clear  = 1'b0;
        id_ex_ena1   = 1'b0;
        id_ex_ena2   = 1'b0;
        id_ex_clear1 = 1'b0;
        id_ex_clear2 = 1'b0;
        ex_mem_ena   = 1'b0;
        ex_mem_clear = 1'b0;
        issue_cnt    = 2'd0;

        if (w_kill_all) begin
            if_id_clear  = 1'b1;
            id_ex_clear1 = 1'b1;
            id_ex_clear2 = 1'b1;
            ex_mem_clear = 1'b1;
        end else if (w_do_issue) begin
            if_id_ena    = 1'b1;
            ex_mem_ena   = 1'b1;
            id_ex_ena1   = d_master_valid;
            id_ex_clear1 = ~d_master_valid;
            id_ex_ena2   = w_dual;
            id_ex_clear2 = ~w_dual;
            issue_cnt    = w_dual ? 2'd2 : (d_master_valid ? 2'd1 : 2'd0);
        end else if (w_run_evt && load_use) begin
            // Hold D, push a bubble into EX, let the load proceed.
            id_ex_clear1 = 1'b1;
            id_ex_clear2 = 1'b1;
            ex_mem_ena   = 1'b1;
        end else if (w_run_evt && branch_flush) begin
            // Master is the delay slot and still issues; the slave and
            // everything fetched behind it is on the wrong path.
            if_id_clear  = 1'b1;
            ex_mem_ena   = 1'b1;
            id_ex_ena1   = d_master_valid;
            id_ex_clear1 = ~d_master_valid;
            id_ex_clear2 = 1'b1;
            issue_cnt    = {1'b0, d_master_valid};
        end
        // Remaining cases (mem_stall, div_start, waiting on the divider)
        // freeze every stage with all controls low.
    end

    // ------------------------------------------------------------------
    // State, counters and sticky watchdog flag.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_ST_RUN;
            r_flush_cnt   <= 3'd0;
            r_div_cnt     <= '0;
            r_div_timeout <= 1'b0;
        end else if (except_flush) begin
            r_state     <= c_ST_FLUSH;
            r_flush_cnt <= 3'(FLUSH_CYCLES - 1);
            r_div_cnt   <= '0;
        end else begin
            case (r_state)
                c_ST_RUN: begin
                    if (!mem_stall && div_start) begin
                        r_state   <= c_ST_DIV;
                        r_div_cnt <= '0;
                    end
                end
                c_ST_DIV: begin
                    if (div_done) begin
                        r_state   <= c_ST_RUN;
                        r_div_cnt <= '0;
                    end else if (w_div_expire) begin
                        r_state       <= c_ST_RUN;
                        r_div_cnt     <= '0;
                        r_div_timeout <= 1'b1;
                    end else begin
                        r_div_cnt <= w_div_nxt;
                    end
                end
                c_ST_FLUSH: begin
                    if (r_flush_cnt == 3'd0) begin
                        r_state <= c_ST_RUN;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - 3'd1;
                    end
                end
                default: begin
                    r_state <= c_ST_RUN;
                end
            endcase
        end
    end

`ifdef ISSUE_STATS_EN
    // Saturating issue statistics; cycles spent flushing are not stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_dual   <= 32'd0;
            stat_single <= 32'd0;
            stat_stall  <= 32'd0;
        end else begin
            if (issue_cnt == 2'd2 && stat_dual != 32'hFFFF_FFFF) begin
                stat_dual <= stat_dual + 32'd1;
            end
            if (issue_cnt == 2'd1 && stat_single != 32'hFFFF_FFFF) begin
                stat_single <= stat_single + 32'd1;
            end
            if (issue_cnt == 2'd0 && r_state != c_ST_FLUSH &&
                stat_stall != 32'hFFFF_FFFF) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dual_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dual_issue_ctrl
// Purpose  : Self-checking bench for dual_issue_ctrl (FLUSH_CYCLES=3,
//            DIV_TIMEOUT=40). Directed scenarios plus a randomized run, all
//            compared against a behavioural model of the controller rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dual_issue_ctrl;

    localparam int c_FC = 3;
    localparam int c_DT = 40;

    localparam int M_RUN   = 0;
    localparam int M_DIV   = 1;
    localparam int M_FLUSH = 2;

    localparam logic [9:0] c_RESET_VEC = 10'b01_0011_0100;

    logic clk = 1'b0;
    logic rst, d_master_valid, d_slave_valid, slave_raw_dep, master_is_mem;
    logic slave_is_mem, slave_is_ctrl, load_use, div_start, div_done;
    logic mem_stall, except_flush, branch_flush;
    logic if_id_ena, if_id_clear, id_ex_ena1, id_ex_ena2;
    logic id_ex_clear1, id_ex_clear2, ex_mem_ena, ex_mem_clear;
    logic [1:0] issue_cnt;
    logic div_timeout;
`ifdef ISSUE_STATS_EN
    logic [31:0] stat_dual, stat_single, stat_stall;
`endif

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int m_mode      = M_RUN;
    int m_flush_rem = 0;
    int m_waited    = 0;
    bit m_timeout   = 1'b0;
    longint m_sd = 0, m_ss = 0, m_st = 0;

    logic [9:0] dut_vec;
    assign dut_vec = {if_id_ena, if_id_clear, id_ex_ena1, id_ex_ena2,
                      id_ex_clear1, id_ex_clear2, ex_mem_ena, ex_mem_clear,
                      issue_cnt};

    dual_issue_ctrl #(.FLUSH_CYCLES(c_FC), .DIV_TIMEOUT(c_DT)) dut (
        .clk(clk), .rst(rst),
        .d_master_valid(d_master_valid), .d_slave_valid(d_slave_valid),
        .slave_raw_dep(slave_raw_dep), .master_is_mem(master_is_mem),
        .slave_is_mem(slave_is_mem), .slave_is_ctrl(slave_is_ctrl),
        .load_use(load_use), .div_start(div_start), .div_done(div_done),
        .mem_stall(mem_stall), .except_flush(except_flush),
        .branch_flush(branch_flush),
        .if_id_ena(if_id_ena), .if_id_clear(if_id_clear),
        .id_ex_ena1(id_ex_ena1), .id_ex_ena2(id_ex_ena2),
        .id_ex_clear1(id_ex_clear1), .id_ex_clear2(id_ex_clear2),
        .ex_mem_ena(ex_mem_ena), .ex_mem_clear(ex_mem_clear),
        .issue_cnt(issue_cnt), .div_timeout(div_timeout)
`ifdef ISSUE_STATS_EN
        , .stat_dual(stat_dual), .stat_single(stat_single),
        .stat_stall(stat_stall)
`endif
    );

    always #5 clk = ~clk;

    // Expected pipeline controls from the current inputs and model mode.
    function automatic logic [9:0] exp_out();
        logic dual, mv, quiet_run;
        dual = d_master_valid && d_slave_valid && !slave_raw_dep &&
               !(master_is_mem && slave_is_mem) && !slave_is_ctrl;
        mv = d_master_valid;
        quiet_run = (m_mode == M_RUN) && !mem_stall && !div_start;
        if (rst || except_flush || m_mode == M_FLUSH)
            return c_RESET_VEC;
        if ((m_mode == M_DIV && div_done) ||
            (quiet_run && !load_use && !branch_flush))
            return {1'b1, 1'b0, mv, dual, !mv, !dual, 1'b1, 1'b0,
                    dual ? 2'd2 : (mv ? 2'd1 : 2'd0)};
        if (quiet_run && load_use)
            return {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0};
        if (quiet_run && branch_flush)
            return {1'b0, 1'b1, mv, 1'b0, !mv, 1'b1, 1'b1, 1'b0, 1'b0, mv};
        return 10'd0;
    endfunction

    // Advance the model across one clock edge using the current inputs.
    task automatic model_advance();
        logic [9:0] e;
        e = exp_out();
        if (rst) begin
            m_sd = 0; m_ss = 0; m_st = 0;
        end else begin
            if (e[1:0] == 2'd2) m_sd++;
            if (e[1:0] == 2'd1) m_ss++;
            if (e[1:0] == 2'd0 && m_mode != M_FLUSH) m_st++;
        end
        if (rst) begin
            m_mode = M_RUN; m_flush_rem = 0; m_waited = 0; m_timeout = 1'b0;
        end else if (except_flush) begin
            m_mode = M_FLUSH; m_flush_rem = c_FC;
        end else if (m_mode == M_RUN) begin
            if (!mem_stall && div_start) begin
                m_mode = M_DIV; m_waited = 0;
            end
        end else if (m_mode == M_DIV) begin
            if (div_done) m_mode = M_RUN;
            else begin
                m_waited++;
                if (m_waited == c_DT) begin
                    m_timeout = 1'b1; m_mode = M_RUN;
                end
            end
        end else begin
            m_flush_rem--;
            if (m_flush_rem == 0) m_mode = M_RUN;
        end
    endtask

    task automatic cyc();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_pair();
        d_master_valid = 1'b1; d_slave_valid = 1'b1; slave_raw_dep = 1'b0;
        master_is_mem = 1'b0; slave_is_mem = 1'b0; slave_is_ctrl = 1'b0;
        load_use = 1'b0; div_start = 1'b0; div_done = 1'b0;
        mem_stall = 1'b0; except_flush = 1'b0; branch_flush = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        quiet_pair();
        rst = 1'b1;
        #1;
        checks++;
        if (dut_vec !== c_RESET_VEC) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected %b", dut_vec, c_RESET_VEC);
        end
        cyc(); cyc();
        checks++;
        if (div_timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_timeout: got %b expected 0", div_timeout);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (dut_vec !== exp_out()) begin
            errors++;
            $display("FAIL reset_release: got %b expected %b", dut_vec, exp_out());
        end
    endtask

    task automatic test_dual_issue();
        quiet_pair();
        for (int i = 0; i < 4; i++) begin
            master_is_mem = 1'($urandom_range(0, 1));
            slave_is_mem  = ~master_is_mem & 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (issue_cnt !== 2'd2 || id_ex_ena1 !== 1'b1 || id_ex_ena2 !== 1'b1 ||
                id_ex_clear2 !== 1'b0) begin
                errors++;
                $display("FAIL dual_issue[%0d]: got cnt=%0d ena1=%b ena2=%b clr2=%b expected 2 1 1 0",
                         i, issue_cnt, id_ex_ena1, id_ex_ena2, id_ex_clear2);
            end
            cyc();
        end
        // Both memory ops cannot pair.
        master_is_mem = 1'b1; slave_is_mem = 1'b1;
        #1;
        checks++;
        if (dut_vec !== exp_out() || issue_cnt !== 2'd1) begin
            errors++;
            $display("FAIL mem_pair: got %b expected %b", dut_vec, exp_out());
        end
        cyc();
    endtask

    task automatic test_raw_dep();
        quiet_pair();
        slave_raw_dep = 1'b1;
        #1;
        checks++;
        if (issue_cnt !== 2'd1 || id_ex_clear2 !== 1'b1) begin
            errors++;
            $display("FAIL raw_dep: got cnt=%0d clr2=%b expected 1 1", issue_cnt, id_ex_clear2);
        end
        cyc();
        slave_raw_dep = 1'b0;
        #1;
        checks++;
        if (issue_cnt !== 2'd2) begin
            errors++;
            $display("FAIL raw_dep_gone: got cnt=%0d expected 2", issue_cnt);
        end
        cyc();
    endtask

    task automatic test_div_done();
        quiet_pair();
        div_start = 1'b1;
        #1;
        checks++;
        if (dut_vec !== 10'd0) begin
            errors++;
            $display("FAIL div_start_cycle: got %b expected %b", dut_vec, 10'd0);
        end
        cyc();
        div_start = 1'b0;
        for (int i = 0; i < 35; i++) begin
            #1;
            checks++;
            if ({if_id_ena, id_ex_ena1, id_ex_ena2, ex_mem_ena} !== 4'b0 ||
                dut_vec !== exp_out()) begin
                errors++;
                $display("FAIL div_wait[%0d]: got %b expected %b", i, dut_vec, exp_out());
            end
            cyc();
        end
        div_done = 1'b1;
        #1;
        checks++;
        if (ex_mem_ena !== 1'b1 || issue_cnt !== 2'd2) begin
            errors++;
            $display("FAIL div_done_cycle: got ex_mem_ena=%b cnt=%0d expected 1 2",
                     ex_mem_ena, issue_cnt);
        end
        cyc();
        div_done = 1'b0;
        #1;
        checks++;
        if (div_timeout !== 1'b0 || issue_cnt !== 2'd2) begin
            errors++;
            $display("FAIL div_after: got timeout=%b cnt=%0d expected 0 2", div_timeout, issue_cnt);
        end
    endtask

    task automatic test_div_timeout();
        quiet_pair();
        div_start = 1'b1;
        cyc();
        div_start = 1'b0;
        for (int i = 0; i < c_DT; i++) begin
            #1;
            checks++;
            if (div_timeout !== 1'b0 || dut_vec !== 10'd0) begin
                errors++;
                $display("FAIL div_timeout_wait[%0d]: got flag=%b vec=%b expected 0 %b",
                         i, div_timeout, dut_vec, 10'd0);
            end
            cyc();
        end
        checks++;
        if (div_timeout !== 1'b1 || issue_cnt !== 2'd2) begin
            errors++;
            $display("FAIL div_timeout_set: got flag=%b cnt=%0d expected 1 2", div_timeout, issue_cnt);
        end
        cyc();
    endtask

    task automatic test_flush_in_div();
        quiet_pair();
        div_start = 1'b1;
        cyc();
        div_start = 1'b0;
        cyc(); cyc();
        except_flush = 1'b1;
        #1;
        checks++;
        if (dut_vec !== c_RESET_VEC) begin
            errors++;
            $display("FAIL except_cycle: got %b expected %b", dut_vec, c_RESET_VEC);
        end
        cyc();
        except_flush = 1'b0;
        for (int i = 0; i < c_FC; i++) begin
            #1;
            checks++;
            if (dut_vec !== c_RESET_VEC) begin
                errors++;
                $display("FAIL flush_hold[%0d]: got %b expected %b", i, dut_vec, c_RESET_VEC);
            end
            cyc();
        end
        #1;
        checks++;
        if (issue_cnt !== 2'd2 || if_id_ena !== 1'b1) begin
            errors++;
            $display("FAIL flush_exit: got cnt=%0d if_id_ena=%b expected 2 1", issue_cnt, if_id_ena);
        end
        cyc();
    endtask

    task automatic test_mem_stall_load_use();
        quiet_pair();
        load_use = 1'b1; mem_stall = 1'b1;
        #1;
        checks++;
        if (dut_vec !== 10'd0) begin
            errors++;
            $display("FAIL mem_stall_wins: got %b expected %b", dut_vec, 10'd0);
        end
        cyc();
        mem_stall = 1'b0;
        #1;
        checks++;
        if (id_ex_clear1 !== 1'b1 || id_ex_clear2 !== 1'b1 || issue_cnt !== 2'd0 ||
            ex_mem_ena !== 1'b1 || if_id_ena !== 1'b0) begin
            errors++;
            $display("FAIL load_use: got %b expected %b", dut_vec, exp_out());
        end
        cyc();
        load_use = 1'b0; branch_flush = 1'b1;
        #1;
        checks++;
        if (issue_cnt !== 2'd1 || if_id_clear !== 1'b1 || id_ex_clear2 !== 1'b1) begin
            errors++;
            $display("FAIL branch_flush: got %b expected %b", dut_vec, exp_out());
        end
        cyc();
    endtask

    task automatic test_reset_mid_flush();
        quiet_pair();
        except_flush = 1'b1;
        cyc();
        except_flush = 1'b0;
        cyc();
        rst = 1'b1;
        #1;
        checks++;
        if (dut_vec !== c_RESET_VEC) begin
            errors++;
            $display("FAIL rst_mid_flush: got %b expected %b", dut_vec, c_RESET_VEC);
        end
        cyc();
        rst = 1'b0;
        #1;
        checks++;
        if (issue_cnt !== 2'd2 || div_timeout !== 1'b0) begin
            errors++;
            $display("FAIL rst_release_run: got cnt=%0d flag=%b expected 2 0", issue_cnt, div_timeout);
        end
        cyc();
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            rst            = ($urandom_range(0, 299) == 0);
            d_master_valid = ($urandom_range(0, 3) != 0);
            d_slave_valid  = ($urandom_range(0, 3) != 0);
            slave_raw_dep  = ($urandom_range(0, 3) == 0);
            master_is_mem  = ($urandom_range(0, 2) == 0);
            slave_is_mem   = ($urandom_range(0, 2) == 0);
            slave_is_ctrl  = ($urandom_range(0, 5) == 0);
            load_use       = ($urandom_range(0, 7) == 0);
            div_start      = ($urandom_range(0, 19) == 0);
            div_done       = ($urandom_range(0, 24) == 0);
            mem_stall      = ($urandom_range(0, 7) == 0);
            except_flush   = ($urandom_range(0, 39) == 0);
            branch_flush   = ($urandom_range(0, 7) == 0);
            #1;
            checks++;
            if (dut_vec !== exp_out() || div_timeout !== m_timeout) begin
                errors++;
                $display("FAIL random[%0d]: got vec=%b flag=%b expected vec=%b flag=%b",
                         i, dut_vec, div_timeout, exp_out(), m_timeout);
            end
            cyc();
        end
`ifdef ISSUE_STATS_EN
        checks++;
        if (stat_dual !== 32'(m_sd) || stat_single !== 32'(m_ss) || stat_stall !== 32'(m_st)) begin
            errors++;
            $display("FAIL stats: got %0d/%0d/%0d expected %0d/%0d/%0d",
                     stat_dual, stat_single, stat_stall, m_sd, m_ss, m_st);
        end
`endif
    endtask

    initial begin
        quiet_pair();
        rst = 1'b1;
        test_reset();
        test_dual_issue();
        test_raw_dep();
        test_div_done();
        test_div_timeout();
        test_flush_in_div();
        test_mem_stall_load_use();
        test_reset_mid_flush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
